multi_edge_pulse: RTL and testbench

Multi-channel, parametrised edge-to-pulse converter; the successor of the team's single-channel rising-edge one-shot. Each channel synchronises an asynchronous level input, detects rising, falling or both edges as selected at run time, and emits a registered pulse stretched to a configurable width. Per-channel sticky event and overrun flags let a status/CPU block poll events it would otherwise miss. It sits between external or cross-domain control lines and the local control logic in the `sys_clk_i` domain.

---
 rtl/multi_edge_pulse_if.sv | 22 ++
 rtl/multi_edge_pulse.sv | 129 ++++++++++++
 tb/tb_multi_edge_pulse.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_edge_pulse_if.sv
// Level-input / pulse-output bundle for multi_edge_pulse.
// master drives inputs and mode, slave is the converter.
interface multi_edge_pulse_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0]   signal_i;
  logic [2*CH_NUM-1:0] mode_i;
  logic [CH_NUM-1:0]   clr_i;
  logic [CH_NUM-1:0]   pulse_o;
  logic [CH_NUM-1:0]   evt_o;
  logic [CH_NUM-1:0]   ovr_o;

  modport master (
    output signal_i, mode_i, clr_i,
    input  pulse_o, evt_o, ovr_o
  );

  modport slave (
    input  signal_i, mode_i, clr_i,
    output pulse_o, evt_o, ovr_o
  );
endinterface

// File: rtl/multi_edge_pulse.sv
// Multi-channel edge-to-pulse converter with sync chain,
// run-time edge select, stretched pulses and sticky flags.
module multi_edge_pulse #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_WIDTH = 1,
  parameter int RETRIG      = 1
) (
  input  logic               sys_clk_i,
  input  logic               rst_n_i,
  multi_edge_pulse_if.slave  bus
);

  localparam int CNT_W = $clog2(PULSE_WIDTH + 1);
  localparam logic [CNT_W-1:0] WIDTH = CNT_W'(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CH_NUM-1:0] pulse_v;
  logic [CH_NUM-1:0] evt_v;
  logic [CH_NUM-1:0] ovr_v;

  assign bus.pulse_o = pulse_v;
  assign bus.evt_o   = evt_v;
  assign bus.ovr_o   = ovr_v;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic             s;
    logic             sig_d;
    logic             rise;
    logic             fall;
    logic             hit;
    logic             busy;
    logic             reload;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse;
    logic             evt;
    logic             ovr;

    assign mode = bus.mode_i[2*c +: 2];

    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = bus.signal_i[c];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;

      // shift the raw level through the synchroniser chain
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          sync <= '0;
        end else begin
          sync[0] <= bus.signal_i[c];
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync[i] <= sync[i-1];
          end
        end
      end

      assign s = sync[SYNC_STAGES-1];
    end

    assign rise = s & ~sig_d;
    assign fall = ~s & sig_d;
    assign hit  = (mode[0] & rise) | (mode[1] & fall);
    assign busy = (cnt != '0);

    // an idle counter always loads; a busy one only if retriggerable
    assign reload = hit & (~busy | (RETRIG != 0));

    // next width-counter value
    always_comb begin
      cnt_nxt = cnt;
      if (reload) begin
        cnt_nxt = WIDTH;
      end else if (busy) begin
        cnt_nxt = cnt - ONE;
      end
    end

    // history tracks s in every mode so enabling never sees stale data
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sig_d <= 1'b0;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        sig_d <= s;
        cnt   <= cnt_nxt;
        pulse <= (cnt_nxt != '0);
      end
    end

    // sticky event flag, set has priority over clear
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        evt <= 1'b0;
      end else if (hit) begin
        evt <= 1'b1;
      end else if (bus.clr_i[c]) begin
        evt <= 1'b0;
      end
    end

    if (RETRIG != 0) begin : g_no_ovr
      assign ovr = 1'b0;
    end else begin : g_ovr
      logic ovr_q;

      // sticky overrun flag for edges dropped during a pulse
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          ovr_q <= 1'b0;
        end else if (hit && busy) begin
          ovr_q <= 1'b1;
        end else if (bus.clr_i[c]) begin
          ovr_q <= 1'b0;
        end
      end

      assign ovr = ovr_q;
    end

    assign pulse_v[c] = pulse;
    assign evt_v[c]   = evt;
    assign ovr_v[c]   = ovr;
  end

endmodule

// File: tb/tb_multi_edge_pulse.sv
// Directed scoreboard bench for multi_edge_pulse: four
// parameter sets, expectations queued by the driver.
module tb_multi_edge_pulse;

  typedef struct packed {
    logic [1:0] d;
    logic [3:0] p;
    logic [3:0] e;
    logic [3:0] o;
    logic [7:0] id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sig_v [4];
  logic [7:0] mode_v [4];
  logic [3:0] clr_v [4];
  exp_t       q [$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] tid = 8'd0;

  always #5 clk = ~clk;

  multi_edge_pulse_if #(.CH_NUM(4)) ifa ();
  multi_edge_pulse_if #(.CH_NUM(4)) ifb ();
  multi_edge_pulse_if #(.CH_NUM(4)) ifc ();
  multi_edge_pulse_if #(.CH_NUM(4)) ifd ();

  assign ifa.signal_i = sig_v[0];
  assign ifa.mode_i   = mode_v[0];
  assign ifa.clr_i    = clr_v[0];
  assign ifb.signal_i = sig_v[1];
  assign ifb.mode_i   = mode_v[1];
  assign ifb.clr_i    = clr_v[1];
  assign ifc.signal_i = sig_v[2];
  assign ifc.mode_i   = mode_v[2];
  assign ifc.clr_i    = clr_v[2];
  assign ifd.signal_i = sig_v[3];
  assign ifd.mode_i   = mode_v[3];
  assign ifd.clr_i    = clr_v[3];

  multi_edge_pulse #(
    .CH_NUM(4), .SYNC_STAGES(2),
    .PULSE_WIDTH(3), .RETRIG(1)
  ) dut_a (
    .sys_clk_i(clk), .rst_n_i(rst_n), .bus(ifa)
  );

  multi_edge_pulse #(
    .CH_NUM(4), .SYNC_STAGES(2),
    .PULSE_WIDTH(4), .RETRIG(1)
  ) dut_b (
    .sys_clk_i(clk), .rst_n_i(rst_n), .bus(ifb)
  );

  multi_edge_pulse #(
    .CH_NUM(4), .SYNC_STAGES(2),
    .PULSE_WIDTH(4), .RETRIG(0)
  ) dut_c (
    .sys_clk_i(clk), .rst_n_i(rst_n), .bus(ifc)
  );

  multi_edge_pulse #(
    .CH_NUM(4), .SYNC_STAGES(0),
    .PULSE_WIDTH(1), .RETRIG(1)
  ) dut_d (
    .sys_clk_i(clk), .rst_n_i(rst_n), .bus(ifd)
  );

  function automatic string tname(logic [7:0] id);
    case (id)
      8'd0:    return "reset";
      8'd1:    return "rise";
      8'd2:    return "mode10";
      8'd3:    return "mode11";
      8'd4:    return "mode00";
      8'd5:    return "retrig";
      8'd6:    return "overrun";
      8'd7:    return "modeoff";
      8'd8:    return "clrset";
      8'd9:    return "rstmid";
      8'd10:   return "bypass";
      default: return "other";
    endcase
  endfunction

  task automatic chk(string nm, string f, logic [3:0] got,
                     logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s @%0t got=%b want=%b",
               nm, f, $time, got, exp);
    end
  endtask

  // monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    exp_t       v;
    logic [3:0] gp, ge, go;
    if (q.size() > 0) begin
      v = q.pop_front();
      case (v.d)
        2'd0: begin gp = ifa.pulse_o; ge = ifa.evt_o; go = ifa.ovr_o; end
        2'd1: begin gp = ifb.pulse_o; ge = ifb.evt_o; go = ifb.ovr_o; end
        2'd2: begin gp = ifc.pulse_o; ge = ifc.evt_o; go = ifc.ovr_o; end
        default: begin
          gp = ifd.pulse_o; ge = ifd.evt_o; go = ifd.ovr_o;
        end
      endcase
      chk(tname(v.id), "pulse", gp, v.p);
      chk(tname(v.id), "evt", ge, v.e);
      chk(tname(v.id), "ovr", go, v.o);
    end
  end

  // apply inputs after an edge and queue the outputs due after it
  task automatic step(int d, bit rst, logic [3:0] sig,
                      logic [7:0] mode, logic [3:0] clr,
                      logic [3:0] ep, logic [3:0] ee,
                      logic [3:0] eo);
    exp_t v;
    @(posedge clk);
    #2;
    rst_n     = rst;
    sig_v[d]  = sig;
    mode_v[d] = mode;
    clr_v[d]  = clr;
    v.d  = 2'(d);
    v.p  = ep;
    v.e  = ee;
    v.o  = eo;
    v.id = tid;
    q.push_back(v);
  endtask

  task automatic run(int d, logic [3:0] sig, logic [7:0] mode,
                     logic [3:0] clr, int n, logic [3:0] ep,
                     logic [3:0] ee, logic [3:0] eo);
    repeat (n) step(d, 1'b1, sig, mode, clr, ep, ee, eo);
  endtask

  task automatic do_reset(int d);
    tid = 8'd0;
    for (int i = 0; i < 4; i++) begin
      sig_v[i]  = '0;
      mode_v[i] = '0;
      clr_v[i]  = '0;
    end
    step(d, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);
    step(d, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);
    step(d, 1'b1, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    logic [3:0] cur, prev, clrc, ee, hit, ns, nc;
    for (int i = 0; i < 4; i++) begin
      sig_v[i]  = '0;
      mode_v[i] = '0;
      clr_v[i]  = '0;
    end

    // rising edge on ch0, S=2 W=3, then fall and clear
    do_reset(0);
    tid = 8'd1;
    run(0, 4'h0, 8'h01, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(0, 4'h1, 8'h01, 4'h0, 3, 4'h0, 4'h0, 4'h0);
    run(0, 4'h1, 8'h01, 4'h0, 3, 4'h1, 4'h1, 4'h0);
    run(0, 4'h1, 8'h01, 4'h0, 1, 4'h0, 4'h1, 4'h0);
    run(0, 4'h0, 8'h01, 4'h0, 5, 4'h0, 4'h1, 4'h0);
    run(0, 4'h0, 8'h01, 4'h1, 1, 4'h0, 4'h1, 4'h0);
    run(0, 4'h0, 8'h01, 4'h0, 2, 4'h0, 4'h0, 4'h0);

    // falling-only on ch3
    do_reset(0);
    tid = 8'd2;
    run(0, 4'h0, 8'h80, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(0, 4'h8, 8'h80, 4'h0, 5, 4'h0, 4'h0, 4'h0);
    run(0, 4'h0, 8'h80, 4'h0, 3, 4'h0, 4'h0, 4'h0);
    run(0, 4'h0, 8'h80, 4'h0, 3, 4'h8, 4'h8, 4'h0);
    run(0, 4'h0, 8'h80, 4'h0, 3, 4'h0, 4'h8, 4'h0);

    // both edges on ch3: pulses five clocks apart
    do_reset(0);
    tid = 8'd3;
    run(0, 4'h0, 8'hC0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(0, 4'h8, 8'hC0, 4'h0, 3, 4'h0, 4'h0, 4'h0);
    run(0, 4'h8, 8'hC0, 4'h0, 2, 4'h8, 4'h8, 4'h0);
    run(0, 4'h0, 8'hC0, 4'h0, 1, 4'h8, 4'h8, 4'h0);
    run(0, 4'h0, 8'hC0, 4'h0, 2, 4'h0, 4'h8, 4'h0);
    run(0, 4'h0, 8'hC0, 4'h0, 3, 4'h8, 4'h8, 4'h0);
    run(0, 4'h0, 8'hC0, 4'h0, 2, 4'h0, 4'h8, 4'h0);

    // disabled channel sees nothing
    do_reset(0);
    tid = 8'd4;
    run(0, 4'h8, 8'h00, 4'h0, 5, 4'h0, 4'h0, 4'h0);
    run(0, 4'h0, 8'h00, 4'h0, 6, 4'h0, 4'h0, 4'h0);

    // retrigger: second edge two clocks later, six-clock pulse
    do_reset(1);
    tid = 8'd5;
    run(1, 4'h0, 8'h03, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(1, 4'h1, 8'h03, 4'h0, 2, 4'h0, 4'h0, 4'h0);
    run(1, 4'h0, 8'h03, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(1, 4'h0, 8'h03, 4'h0, 6, 4'h1, 4'h1, 4'h0);
    run(1, 4'h0, 8'h03, 4'h0, 2, 4'h0, 4'h1, 4'h0);

    // pulse finishes after mode drops to 00; re-enable is clean
    do_reset(1);
    tid = 8'd7;
    run(1, 4'h0, 8'h01, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(1, 4'h1, 8'h01, 4'h0, 3, 4'h0, 4'h0, 4'h0);
    run(1, 4'h1, 8'h00, 4'h0, 4, 4'h1, 4'h1, 4'h0);
    run(1, 4'h0, 8'h00, 4'h0, 2, 4'h0, 4'h1, 4'h0);
    run(1, 4'h1, 8'h00, 4'h0, 3, 4'h0, 4'h1, 4'h0);
    run(1, 4'h1, 8'h01, 4'h0, 5, 4'h0, 4'h1, 4'h0);

    // no retrigger: four-clock pulse and overrun, then clear
    do_reset(2);
    tid = 8'd6;
    run(2, 4'h0, 8'h03, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(2, 4'h1, 8'h03, 4'h0, 2, 4'h0, 4'h0, 4'h0);
    run(2, 4'h0, 8'h03, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(2, 4'h0, 8'h03, 4'h0, 2, 4'h1, 4'h1, 4'h0);
    run(2, 4'h0, 8'h03, 4'h0, 2, 4'h1, 4'h1, 4'h1);
    run(2, 4'h0, 8'h03, 4'h0, 3, 4'h0, 4'h1, 4'h1);
    run(2, 4'h0, 8'h03, 4'h1, 1, 4'h0, 4'h1, 4'h1);
    run(2, 4'h0, 8'h03, 4'h0, 2, 4'h0, 4'h0, 4'h0);

    // clear colliding with a hit on ch1: set wins
    do_reset(0);
    tid = 8'd8;
    run(0, 4'h0, 8'h04, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(0, 4'h2, 8'h04, 4'h0, 2, 4'h0, 4'h0, 4'h0);
    run(0, 4'h2, 8'h04, 4'h2, 1, 4'h0, 4'h0, 4'h0);
    run(0, 4'h2, 8'h04, 4'h2, 1, 4'h2, 4'h2, 4'h0);
    run(0, 4'h2, 8'h04, 4'h0, 2, 4'h2, 4'h0, 4'h0);
    run(0, 4'h2, 8'h04, 4'h0, 1, 4'h0, 4'h0, 4'h0);

    // async reset mid-pulse on ch2, then power-up edge
    do_reset(0);
    tid = 8'd9;
    run(0, 4'h0, 8'h10, 4'h0, 1, 4'h0, 4'h0, 4'h0);
    run(0, 4'h4, 8'h10, 4'h0, 3, 4'h0, 4'h0, 4'h0);
    run(0, 4'h4, 8'h10, 4'h0, 1, 4'h4, 4'h4, 4'h0);
    step(0, 1'b0, 4'h4, 8'h10, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 1'b0, 4'h4, 8'h10, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 1'b1, 4'h4, 8'h10, 4'h0, 4'h0, 4'h0, 4'h0);
    run(0, 4'h4, 8'h10, 4'h0, 2, 4'h0, 4'h0, 4'h0);
    run(0, 4'h4, 8'h10, 4'h0, 3, 4'h4, 4'h4, 4'h0);
    run(0, 4'h4, 8'h10, 4'h0, 2, 4'h0, 4'h4, 4'h0);

    // bypass, W=1: ch0 off, ch1 rise, ch2 fall, ch3 both
    do_reset(3);
    tid  = 8'd10;
    cur  = '0;
    prev = '0;
    clrc = '0;
    ee   = '0;
    for (int i = 0; i < 80; i++) begin
      hit = (4'b1010 & cur & ~prev) | (4'b1100 & ~cur & prev);
      ee  = hit | (ee & ~clrc);
      ns  = 4'($urandom);
      nc  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      step(3, 1'b1, ns, 8'hE4, nc, hit, ee, 4'h0);
      prev = cur;
      cur  = ns;
      clrc = nc;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
